// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and width helpers for the time-multiplexed FIR
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round half up, arithmetic shift and saturate the accumulator
module fir_round_sat #(
  parameter int ACC_W = 36,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  // One extra bit keeps the rounding add from wrapping at the accumulator extremes.
  localparam logic signed [ACC_W:0] HALF = ((ACC_W + 1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shr;

  always_comb begin
    ext = {acc[ACC_W-1], acc};
    rnd = ext + HALF;
    shr = rnd >>> SHIFT;
    if (shr > MAXV) begin
      data = MAXV[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shr < MINV) begin
      data = MINV[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = shr[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/fir_tdm_mac.sv
// rtl/fir_tdm_mac.sv - multi-channel FIR sharing one multiply-accumulate engine
module fir_tdm_mac
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 16,
  parameter int SHIFT    = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_data,
  input  logic [chan_width(CHANNELS)-1:0] s_chan,
  input  logic                            coef_we,
  input  logic [$clog2(TAPS)-1:0]         coef_addr,
  input  logic [COEF_W-1:0]               coef_data,
  output logic                            coef_ready,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [OUT_W-1:0]                m_data,
  output logic [chan_width(CHANNELS)-1:0] m_chan,
  output logic                            m_sat
);

  localparam int CW    = chan_width(CHANNELS);
  localparam int AW    = $clog2(TAPS);
  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam logic [AW:0]   TAPS_L = (AW + 1)'(TAPS);
  localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);

  state_t state;

  logic signed [COEF_W-1:0] coef  [TAPS];
  logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
  logic [AW-1:0]            wptr  [CHANNELS];

  logic [AW-1:0]            cur_ptr;
  logic [AW-1:0]            k;
  logic [CW-1:0]            cur_chan;
  logic signed [ACC_W-1:0]  acc;
  logic                     rdy;
  logic                     out_valid;

  // Coefficient overwritten on the accept edge; the sample in flight must still see the old value.
  logic                     shadow_en;
  logic [AW-1:0]            shadow_addr;
  logic signed [COEF_W-1:0] shadow_val;

  logic                     s_fire;
  logic                     coef_fire;
  logic                     chan_ok;
  logic [AW-1:0]            wp_cur;
  logic [AW-1:0]            wp_next;
  logic [AW-1:0]            rd_idx;
  logic signed [DATA_W-1:0] x_rd;
  logic signed [COEF_W-1:0] h_rd;
  logic signed [PW-1:0]     prod;
  logic [OUT_W-1:0]         rs_data;
  logic                     rs_sat;

  assign s_ready    = rdy & ~rst;
  assign coef_ready = rdy & ~rst;
  assign s_fire     = s_valid & s_ready;
  assign coef_fire  = coef_we & coef_ready;
  assign chan_ok    = int'(s_chan) < CHANNELS;

  always_comb begin
    wp_cur  = wptr[s_chan];
    wp_next = (wp_cur == LAST_K) ? '0 : wp_cur + 1'b1;
    // Tap k sits k slots behind the newest sample, modulo the line length.
    rd_idx  = (k > cur_ptr) ? AW'({1'b0, cur_ptr} + TAPS_L - {1'b0, k}) : cur_ptr - k;
    x_rd    = dline[cur_chan][rd_idx];
    h_rd    = (shadow_en && shadow_addr == k) ? shadow_val : coef[k];
    prod    = PW'(x_rd) * PW'(h_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rdy         <= 1'b0;
      out_valid   <= 1'b0;
      acc         <= '0;
      k           <= '0;
      cur_ptr     <= '0;
      cur_chan    <= '0;
      shadow_en   <= 1'b0;
      shadow_addr <= '0;
      shadow_val  <= '0;
      for (int t = 0; t < TAPS; t++) begin
        coef[t] <= '0;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) begin
          dline[c][t] <= '0;
        end
      end
    end else begin
      if (coef_fire) begin
        coef[coef_addr] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (s_fire && chan_ok) begin
            dline[s_chan][wp_next] <= s_data;
            wptr[s_chan]           <= wp_next;
            cur_chan               <= s_chan;
            cur_ptr                <= wp_next;
            k                      <= '0;
            acc                    <= '0;
            shadow_en              <= coef_fire;
            shadow_addr            <= coef_addr;
            shadow_val             <= coef[coef_addr];
            rdy                    <= 1'b0;
            state                  <= MAC;
          end else begin
            rdy <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (k == LAST_K) begin
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            out_valid <= 1'b0;
            rdy       <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fir_round_sat #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .acc (acc),
    .data(rs_data),
    .sat (rs_sat)
  );

  assign m_valid = out_valid & ~rst;
  assign m_data  = rst ? '0 : rs_data;
  assign m_chan  = rst ? '0 : cur_chan;
  assign m_sat   = rs_sat & ~rst;

endmodule

// File: doc/fir_tdm_mac.md
# fir_tdm_mac

Time-multiplexed, multi-channel FIR filter with a single multiply-accumulate engine.
- Parametrised successor to the team's fully parallel N-tap FIR.
- Adds valid/ready streaming on input and output, per-channel delay lines, a runtime coefficient write port, and rounding plus saturation to a narrower output.
- Sits between the sample source (ADC/decimator front end) and downstream DSP stages, where tap count × channels is too costly for a parallel multiplier array.

## Interface
Parameters:
- DATA_W, 16, input sample width, signed
- COEF_W, 16, coefficient width, signed
- TAPS, 16, taps per channel (≥2)
- CHANNELS, 2, independent channels sharing one coefficient set (≥1)
- OUT_W, 16, output width, signed
- SHIFT, 15, arithmetic right shift applied to the accumulator before saturation (0..ACC_W-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  engine can accept a sample
- s_data  in  DATA_W  signed sample
- s_chan  in  CW  channel index; CW = max(1,$clog2(CHANNELS))
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(TAPS)  tap index
- coef_data  in  COEF_W  signed coefficient
- coef_ready  out  1  coefficient write will be accepted this cycle
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  OUT_W  filtered, rounded, saturated result
- m_chan  out  CW  channel of m_data
- m_sat  out  1  m_data was clipped

## Operation
FSM states and transitions:
- IDLE: s_ready=1, coef_ready=1.
  - On s_valid&&s_ready with s_chan<CHANNELS: write the sample as newest tap of that channel's delay line (circular pointer per channel, oldest discarded), clear the accumulator, go to MAC.
  - On s_valid&&s_ready with s_chan≥CHANNELS: sample is consumed and dropped; stay in IDLE; no output.
- MAC: one product h[k]·x[n−k] per cycle, k=0..TAPS−1, including the sample just written. After TAPS cycles go to OUT.
- OUT: m_valid=1, m_data, m_chan and m_sat held stable. On m_valid&&m_ready go to IDLE.

Arithmetic:
- Accumulator width ACC_W = DATA_W+COEF_W+$clog2(TAPS); the accumulator never wraps.
- If SHIFT>0, add 2^(SHIFT−1) (round half up), then arithmetic shift right by SHIFT.
- Clip the result to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; m_sat=1 when clipped.

Coefficients:
- Accepted only when coef_we&&coef_ready; writes outside IDLE are dropped (no queueing).
- A write takes effect for samples accepted from the next cycle onward.

Reset:
- Clears all delay lines and coefficients to 0, FSM to IDLE, and drops any result in flight.
- Output values while rst=1: s_ready=0, coef_ready=0, m_valid=0, m_data=0, m_chan=0, m_sat=0.
- s_ready and coef_ready rise the cycle after rst deasserts.

## Timing
- Input accepted at edge T; MAC runs over cycles T+1..T+TAPS; m_valid is high from cycle T+TAPS+1.
- Latency is TAPS+1 cycles; maximum throughput is one sample per TAPS+2 cycles with m_ready tied high.
- s_ready returns high the cycle after the output handshake; a new sample may be accepted on that cycle.
- Backpressure: m_valid stays high and m_* are stable until m_ready. There is no output skid; s_ready stays low throughout.
- Simultaneous coef_we and s_valid in IDLE: both are accepted. The sample uses the old coefficient, the write lands at the same edge.
- Reset mid-MAC or mid-OUT: m_valid is 0 in the cycle rst is sampled; the partial result is lost.

## Structure
- Package fir_pkg holds:
  - state enum {IDLE, MAC, OUT}
  - function acc_width(DATA_W, COEF_W, TAPS)
  - function chan_width(CHANNELS)
- Sub-module fir_round_sat: combinational round, shift and saturate from ACC_W to OUT_W, outputs data and sat flag; instantiated once on the accumulator output register.
- Delay lines and coefficients are register arrays, with one read port each per cycle.

## Test plan
1. Impulse, default parameters, h[k]=1000·(k+1), ch0 x=32767 then 15 zeros → ch0 outputs 1000, 2000, …, 16000, then 0; m_sat=0.
2. Saturation: all h=32767, 16 samples x=32767 → final m_data=32767, m_sat=1. Same run with x=−32768 → m_data=−32768, m_sat=1.
3. Channel isolation: CHANNELS=2, interleaved ch0 impulse (32767) and ch1 zeros, h as in test 1 → ch1 always 0, ch0 matches test 1, m_chan alternates 0,1.
4. Backpressure: m_ready held low 5 cycles in OUT → m_data stable, s_ready=0 throughout. A sample offered the cycle after the handshake is accepted and its m_valid appears TAPS+1 cycles later.
5. Coefficient hazard: coef_we during MAC → coef_ready=0 and the write is dropped (readback via a following impulse unchanged). The same write in IDLE, coincident with s_valid, affects only the next sample.
6. Reset mid-MAC, then impulse x=32767 on ch0 → no stale m_valid; outputs 0 for all taps because coefficients were cleared. After reloading coefficients, the response matches test 1 exactly, with no history from before reset.
